alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
//
// PURPOSE
//   Shares one 32-bit RISC-V ALU between two requesters (port 0, port 1).
//   Each requester presents an operand pair and a 4-bit ALU op code on a
//   valid/ready request channel. The winner is chosen round-robin and its
//   operation is sequenced through the ALU. Result and zero flag return on
//   that requester's valid/ready response channel.
//   Sits between the issue logic and the ALU datapath.
//
// PARAMETERS
//   WIDTH   32  operand/result width
//   CTRL_W  4   ALU op code width; passed through unmodified, never decoded
//
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   req0_valid   in   1       port 0 request valid
//   req0_ready   out  1       port 0 request accepted this cycle
//   req0_a       in   WIDTH   port 0 operand A
//   req0_b       in   WIDTH   port 0 operand B
//   req0_ctrl    in   CTRL_W  port 0 ALU op code
//   req1_*       -    -       same as req0_* for port 1
//   rsp0_valid   out  1       port 0 response valid
//   rsp0_ready   in   1       port 0 response consumed
//   rsp0_result  out  WIDTH   port 0 ALU result
//   rsp0_z       out  1       port 0 zero flag
//   rsp1_*       -    -       same as rsp0_* for port 1
//   alu_a        out  WIDTH   registered operand A to ALU
//   alu_b        out  WIDTH   registered operand B to ALU
//   alu_ctrl     out  CTRL_W  registered op code to ALU
//   alu_result   in   WIDTH   ALU result (combinational from alu_* outputs)
//   alu_z        in   1       ALU zero flag
//   busy         out  1       high in every state except IDLE
//
// BEHAVIOUR
//   States:
//     IDLE -> EXEC  when any reqN_valid is high; the grant is taken
//     EXEC -> RESP  always
//     RESP -> IDLE  on rspG_valid && rspG_ready
//   Grant (IDLE only):
//     - If only one port is valid, that port wins.
//     - If both are valid, the port selected by rr_ptr wins.
//     - rr_ptr resets to 0.
//     - At the RESP handshake, rr_ptr becomes ~G.
//   reqN_ready is combinational: (state==IDLE) && (grant==N).
//     - Never high for both ports in the same cycle.
//     - Never high outside IDLE.
//   Accept cycle T: alu_a/b/ctrl <= winner's operands; G is latched.
//   EXEC (T+1): ALU inputs are stable.
//     - rspG_result <= alu_result
//     - rspG_z <= alu_z
//   RESP (T+2 onward):
//     - rspG_valid is high.
//     - result and z are held stable until the handshake.
//     - The other port's rsp_valid stays low.
//   Timing:
//     - Latency from accept to rsp_valid is 2 cycles.
//     - If rsp_ready is already high, the next accept is 3 cycles after the
//       previous one, so minimum initiation interval = 3.
//   Back-pressure: while in RESP, both req_ready stay low.
//   alu_a/b/ctrl hold their last values outside the accept cycle.
//   No arithmetic is performed here; widths pass straight through.
//   Reset, including mid-operation:
//     - state=IDLE, rr_ptr=0, G=0.
//     - All rsp_valid, rsp_result, rsp_z, alu_a/b/ctrl = 0 and busy = 0
//       from the first cycle after rst is sampled high.
//     - The in-flight operation is dropped and no response is issued.
//   Request-side rule: a requester that drops valid before ready is
//   illegal; behaviour is defined only for valid held until ready.
//
// TESTING
//   ALU side uses a behavioural stub: alu_result = alu_a ^ alu_b,
//   alu_z = (alu_result == 0).
//   1. req0 only, A=5, B=10, ctrl=6, rsp0_ready=1
//      -> req0_ready at T; alu_ctrl=6 at T+1;
//         rsp0_valid at T+2, result=15, z=0; rsp1_valid never high.
//   2. Both ports valid from reset, rsp_ready=1, six ops
//      -> grant order 0,1,0,1,0,1; accepts every 3 cycles.
//   3. req0 A=10, B=10 with rsp0_ready low for 5 cycles
//      -> rsp0_valid=1, result=0, z=1 held stable;
//         req1_ready=0 throughout; req1 accepted the cycle after the handshake.
//   4. req1 only, 3 back-to-back ops (127^1, 30^10, 5^5)
//      -> results 126, 20, 0 in order on rsp1, with z=0, 0, 1.
//   5. rst pulsed during EXEC
//      -> no response; the next cycle has outputs zero and busy=0;
//         a fresh request with both ports valid grants port 0.
//   6. rsp0_ready held high with no request
//      -> rsp0_valid stays 0 and state stays IDLE.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that sequences two requesters through one shared ALU.
// Each port has its own response register lane; the ALU operands are registered at accept.

module alu_share_rsp_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_z
);
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
        end else if (load) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_z      <= alu_z;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end
endmodule

module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_z,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_z,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_z,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                        state;
    logic                          g, rr_ptr, grant;
    logic [1:0]                    req_valid, req_ready, rsp_valid, rsp_ready, rsp_z;
    logic [1:0][WIDTH-1:0]         req_a, req_b, rsp_result;
    logic [1:0][CTRL_W-1:0]        req_ctrl;

    assign req_valid = {req1_valid, req0_valid};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign req_ctrl  = {req1_ctrl, req0_ctrl};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A lone requester wins outright; rr_ptr only breaks ties.
    always_comb begin
        grant = rr_ptr;
        if (req_valid == 2'b01)      grant = 1'b0;
        else if (req_valid == 2'b10) grant = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            g        <= 1'b0;
            rr_ptr   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    g        <= grant;
                    alu_a    <= req_a[grant];
                    alu_b    <= req_b[grant];
                    alu_ctrl <= req_ctrl[grant];
                    state    <= EXEC;
                end
                EXEC: state <= RESP;
                RESP: if (rsp_valid[g] && rsp_ready[g]) begin
                    rr_ptr <= ~g;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_lane
        assign req_ready[i] = (state == IDLE) && req_valid[i] && (grant == 1'(i));

        alu_share_rsp_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      ((state == EXEC) && (g == 1'(i))),
            .alu_result(alu_result),
            .alu_z     (alu_z),
            .rsp_ready (rsp_ready[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_result(rsp_result[i]),
            .rsp_z     (rsp_z[i])
        );
    end

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result[0];
    assign rsp1_result = rsp_result[1];
    assign rsp0_z      = rsp_z[0];
    assign rsp1_z      = rsp_z[1];
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an XOR ALU stub; inputs driven and
// outputs sampled on the falling edge.

module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp0_z, rsp1_valid, rsp1_ready, rsp1_z;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_z, busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign alu_result = alu_a ^ alu_b;
    assign alu_z      = (alu_result == 32'd0);

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_z(rsp0_z),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_z(rsp1_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_z(alu_z), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One full transaction on port p, with the other port idle and rsp_ready high.
    task automatic do_op(input string tag, input bit p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [31:0] er, input logic ez);
        int n;
        @(negedge clk);
        if (p) begin req1_valid = 1; req1_a = a; req1_b = b; req1_ctrl = c; end
        else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_ctrl = c; end
        #1;
        n = 0;
        while (!(p ? req1_ready : req0_ready) && n < 10) begin step(); n++; end
        chk({tag, " accept"}, 32'(p ? req1_ready : req0_ready), 1);
        chk({tag, " other_rdy"}, 32'(p ? req0_ready : req1_ready), 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(c));
        chk({tag, " alu_a"}, alu_a, a);
        chk({tag, " busy"}, 32'(busy), 1);
        n = 0;
        while (!(p ? rsp1_valid : rsp0_valid) && n < 10) begin step(); n++; end
        chk({tag, " latency"}, n, 1);
        chk({tag, " result"}, p ? rsp1_result : rsp0_result, er);
        chk({tag, " z"}, 32'(p ? rsp1_z : rsp0_z), 32'(ez));
        chk({tag, " other_rsp"}, 32'(p ? rsp0_valid : rsp1_valid), 0);
    endtask

    initial begin
        int n, k, last, cyc;
        rst = 1; req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_ctrl = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (2) step();
        rst = 0;
        step();
        chk("rst busy", 32'(busy), 0);
        chk("rst rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst alu_a", alu_a, 0);

        // 1: single op on port 0
        do_op("t1", 0, 5, 10, 6, 15, 0);
        step();
        chk("t1 idle", 32'(busy), 0);
        chk("t1 rsp0 cleared", 32'(rsp0_valid), 0);

        // 2: both ports, round-robin from reset
        rst = 1; step(); rst = 0;
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_ctrl = 1;
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_ctrl = 2;
        #1;
        k = 0; last = 0; cyc = 0;
        while (k < 6 && cyc < 40) begin
            if (req0_ready || req1_ready) begin
                chk("t2 grant", 32'(req1_ready), 32'(k % 2));
                chk("t2 single_rdy", 32'(req0_ready & req1_ready), 0);
                if (k > 0) chk("t2 ii", cyc - last, 3);
                last = cyc; k++;
            end
            step(); cyc++;
        end
        chk("t2 six grants", k, 6);
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();

        // 3: port 0 stalled in RESP, port 1 waiting
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 10; req0_b = 10; req0_ctrl = 0;
        req1_valid = 1; req1_a = 3; req1_b = 1; req1_ctrl = 0;
        #1;
        chk("t3 req0_ready", 32'(req0_ready), 1);
        chk("t3 req1_ready@T", 32'(req1_ready), 0);
        step();
        req0_valid = 0;
        #1;
        chk("t3 req1_ready exec", 32'(req1_ready), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3 hold valid", 32'(rsp0_valid), 1);
            chk("t3 hold result", rsp0_result, 0);
            chk("t3 hold z", 32'(rsp0_z), 1);
            chk("t3 req1 blocked", 32'(req1_ready), 0);
        end
        rsp0_ready = 1;
        #1;
        chk("t3 req1 blocked hs", 32'(req1_ready), 0);
        step();
        chk("t3 req1 after hs", 32'(req1_ready), 1);
        step();
        req1_valid = 0;
        step();
        chk("t3 rsp1 valid", 32'(rsp1_valid), 1);
        chk("t3 rsp1 result", rsp1_result, 2);

        // 4: port 1 back-to-back
        do_op("t4a", 1, 127, 1, 3, 126, 0);
        do_op("t4b", 1, 30, 10, 4, 20, 0);
        do_op("t4c", 1, 5, 5, 5, 0, 1);

        // 5: reset mid-operation; a port-0 op first leaves rr_ptr pointing at port 1
        do_op("t5pre", 0, 9, 1, 1, 8, 0);
        @(negedge clk);
        req1_valid = 1; req1_a = 7; req1_b = 2; req1_ctrl = 3;
        #1;
        chk("t5 accept", 32'(req1_ready), 1);
        step();
        req1_valid = 0; rst = 1;
        step();
        rst = 0;
        chk("t5 busy", 32'(busy), 0);
        chk("t5 alu_a", alu_a, 0);
        chk("t5 alu_ctrl", 32'(alu_ctrl), 0);
        chk("t5 rsp1_result", rsp1_result, 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin step(); n += int'(rsp1_valid); end
        chk("t5 no rsp", n, 0);
        req0_valid = 1; req0_a = 4; req0_b = 4; req1_valid = 1;
        #1;
        chk("t5 grant0", 32'(req0_ready), 1);
        chk("t5 not1", 32'(req1_ready), 0);
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();

        // 6: response ready with nothing pending
        rsp0_ready = 1;
        n = 0;
        for (int i = 0; i < 4; i++) begin step(); n += int'(rsp0_valid) + int'(busy); end
        chk("t6 quiet", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
